// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one external memory port between the fetch stage
// (loads only) and the access stage (loads and stores).
//
// Ports:
//   clockIn, resetIn         clock (rising edge), asynchronous active-low reset
//   fetchAddressIn           fetch load address
//   fetchLoadIn              fetch request (level, held until fetchReadyOut)
//   fetchValueOut            fetch load result, valid with fetchReadyOut
//   fetchReadyOut            one-cycle completion pulse to fetch
//   accessAddressIn          access address
//   accessValueIn            access store data
//   accessLoadIn             access load request (level)
//   accessStoreIn            access store request (level, wins over load)
//   accessValueOut           access load result, valid with accessReadyOut
//   accessReadyOut           one-cycle completion pulse to access
//   memoryAddressOut         address to memory
//   memoryValueOut           store data to memory
//   memoryLoadOut            load strobe, held for the whole transaction
//   memoryStoreOut           store strobe, held for the whole transaction
//   memoryValueIn            memory read data, valid with memoryReadyIn
//   memoryReadyIn            memory completion
//   errorOut                 one-cycle pulse when the watchdog aborts
//
// Contention is resolved by alternating priority via a last-grant bit.
// A watchdog (TIMEOUT cycles, 0 = disabled) aborts a hung transaction.
module memory_arbiter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clockIn,
    input  logic             resetIn,
    input  logic [WIDTH-1:0] fetchAddressIn,
    input  logic             fetchLoadIn,
    output logic [WIDTH-1:0] fetchValueOut,
    output logic             fetchReadyOut,
    input  logic [WIDTH-1:0] accessAddressIn,
    input  logic [WIDTH-1:0] accessValueIn,
    input  logic             accessLoadIn,
    input  logic             accessStoreIn,
    output logic [WIDTH-1:0] accessValueOut,
    output logic             accessReadyOut,
    output logic [WIDTH-1:0] memoryAddressOut,
    output logic [WIDTH-1:0] memoryValueOut,
    output logic             memoryLoadOut,
    output logic             memoryStoreOut,
    input  logic [WIDTH-1:0] memoryValueIn,
    input  logic             memoryReadyIn,
    output logic             errorOut
);

    localparam int unsigned CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Abort is decided in the last strobe cycle, so the strobe lasts TIMEOUT cycles.
    localparam int unsigned TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StFetch   = 2'd1;
    localparam logic [1:0] StAccess  = 2'd2;
    localparam logic [1:0] StRespond = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             last_access_q, last_access_d;  // 1: last grant went to access
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             store_q, store_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] fetch_value_q, fetch_value_d;
    logic [WIDTH-1:0] access_value_q, access_value_d;
    logic             fetch_ready_q, fetch_ready_d;
    logic             access_ready_q, access_ready_d;
    logic             error_q, error_d;

    logic access_pend;
    logic fetch_pend;
    logic grant_access;
    logic timeout_hit;

    assign access_pend  = accessLoadIn | accessStoreIn;
    assign fetch_pend   = fetchLoadIn;
    assign grant_access = access_pend & (~fetch_pend | ~last_access_q);
    assign timeout_hit  = (TIMEOUT > 0) && (count_q == CW'(TMO_LAST));

    always_comb begin
        state_d        = state_q;
        last_access_d  = last_access_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        store_d        = store_q;
        count_d        = count_q;
        fetch_value_d  = fetch_value_q;
        access_value_d = access_value_q;
        fetch_ready_d  = 1'b0;
        access_ready_d = 1'b0;
        error_d        = 1'b0;

        case (state_q)
            StIdle: begin
                count_d = '0;
                if (grant_access) begin
                    state_d       = StAccess;
                    last_access_d = 1'b1;
                    addr_d        = accessAddressIn;
                    store_d       = accessStoreIn;
                    wdata_d       = accessStoreIn ? accessValueIn : '0;
                end else if (fetch_pend) begin
                    state_d       = StFetch;
                    last_access_d = 1'b0;
                    addr_d        = fetchAddressIn;
                    store_d       = 1'b0;
                    wdata_d       = '0;
                end
            end
            StFetch, StAccess: begin
                // A completion in the abort cycle wins over the abort.
                if (memoryReadyIn || timeout_hit) begin
                    state_d = StRespond;
                    count_d = '0;
                    error_d = ~memoryReadyIn;
                    if (state_q == StFetch) begin
                        fetch_ready_d = 1'b1;
                        fetch_value_d = memoryReadyIn ? memoryValueIn : '0;
                    end else begin
                        access_ready_d = 1'b1;
                        access_value_d = (memoryReadyIn && !store_q) ? memoryValueIn : '0;
                    end
                end else if (count_q < CW'(TIMEOUT)) begin
                    count_d = count_q + CW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            state_q        <= StIdle;
            last_access_q  <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            store_q        <= 1'b0;
            count_q        <= '0;
            fetch_value_q  <= '0;
            access_value_q <= '0;
            fetch_ready_q  <= 1'b0;
            access_ready_q <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_access_q  <= last_access_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            store_q        <= store_d;
            count_q        <= count_d;
            fetch_value_q  <= fetch_value_d;
            access_value_q <= access_value_d;
            fetch_ready_q  <= fetch_ready_d;
            access_ready_q <= access_ready_d;
            error_q        <= error_d;
        end
    end

    // Strobes decode straight from registered state, so reset clears them at once.
    assign memoryLoadOut    = (state_q == StFetch) | ((state_q == StAccess) & ~store_q);
    assign memoryStoreOut   = (state_q == StAccess) & store_q;
    assign memoryAddressOut = addr_q;
    assign memoryValueOut   = wdata_q;
    assign fetchValueOut    = fetch_value_q;
    assign fetchReadyOut    = fetch_ready_q;
    assign accessValueOut   = access_value_q;
    assign accessReadyOut   = access_ready_q;
    assign errorOut         = error_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed stimulus with a response scoreboard for memory_arbiter.
// The main process drives requests and the memory side, pushes the expected
// completion into a queue; the monitor pops and compares on every ready pulse.
module tb_memory_arbiter;

    logic        clockIn = 1'b0;
    logic        resetIn;
    logic [31:0] fetchAddressIn;
    logic        fetchLoadIn;
    logic [31:0] fetchValueOut;
    logic        fetchReadyOut;
    logic [31:0] accessAddressIn;
    logic [31:0] accessValueIn;
    logic        accessLoadIn;
    logic        accessStoreIn;
    logic [31:0] accessValueOut;
    logic        accessReadyOut;
    logic [31:0] memoryAddressOut;
    logic [31:0] memoryValueOut;
    logic        memoryLoadOut;
    logic        memoryStoreOut;
    logic [31:0] memoryValueIn;
    logic        memoryReadyIn;
    logic        errorOut;

    memory_arbiter #(
        .WIDTH  (32),
        .TIMEOUT(4)
    ) dut (
        .clockIn         (clockIn),
        .resetIn         (resetIn),
        .fetchAddressIn  (fetchAddressIn),
        .fetchLoadIn     (fetchLoadIn),
        .fetchValueOut   (fetchValueOut),
        .fetchReadyOut   (fetchReadyOut),
        .accessAddressIn (accessAddressIn),
        .accessValueIn   (accessValueIn),
        .accessLoadIn    (accessLoadIn),
        .accessStoreIn   (accessStoreIn),
        .accessValueOut  (accessValueOut),
        .accessReadyOut  (accessReadyOut),
        .memoryAddressOut(memoryAddressOut),
        .memoryValueOut  (memoryValueOut),
        .memoryLoadOut   (memoryLoadOut),
        .memoryStoreOut  (memoryStoreOut),
        .memoryValueIn   (memoryValueIn),
        .memoryReadyIn   (memoryReadyIn),
        .errorOut        (errorOut)
    );

    always #5 clockIn = ~clockIn;

    typedef struct packed {
        logic        is_fetch;
        logic [31:0] value;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          n_checks;
    int          n_fail;
    logic [31:0] exp_fetch_val;
    logic [31:0] exp_access_val;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_resp(input logic is_fetch, input logic [31:0] value, input logic err);
        exp_t e;
        e.is_fetch = is_fetch;
        e.value    = value;
        e.err      = err;
        sb.push_back(e);
    endtask

    // One cycle step; inputs are driven and outputs sampled at the falling edge.
    task automatic next();
        @(negedge clockIn);
    endtask

    always @(negedge clockIn) begin : monitor
        exp_t e;
        if (resetIn) begin
            check("strobe_exclusive", 32'(memoryLoadOut & memoryStoreOut), 32'd0);
            if (fetchReadyOut || accessReadyOut) begin
                if (sb.size() == 0) begin
                    check("unexpected_ready", {30'd0, fetchReadyOut, accessReadyOut}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("fetch_ready", 32'(fetchReadyOut), 32'(e.is_fetch));
                    check("access_ready", 32'(accessReadyOut), 32'(!e.is_fetch));
                    check("error_flag", 32'(errorOut), 32'(e.err));
                    if (e.is_fetch) begin
                        check("fetch_value", fetchValueOut, e.value);
                        check("access_value_held", accessValueOut, exp_access_val);
                        exp_fetch_val = e.value;
                    end else begin
                        check("access_value", accessValueOut, e.value);
                        check("fetch_value_held", fetchValueOut, exp_fetch_val);
                        exp_access_val = e.value;
                    end
                end
            end else begin
                check("no_error_outside_respond", 32'(errorOut), 32'd0);
            end
        end
    end

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        exp_fetch_val   = '0;
        exp_access_val  = '0;
        resetIn         = 1'b0;
        fetchAddressIn  = '0;
        fetchLoadIn     = 1'b0;
        accessAddressIn = '0;
        accessValueIn   = '0;
        accessLoadIn    = 1'b0;
        accessStoreIn   = 1'b0;
        memoryValueIn   = '0;
        memoryReadyIn   = 1'b0;

        repeat (2) next();
        check("rst_load", 32'(memoryLoadOut), 32'd0);
        check("rst_store", 32'(memoryStoreOut), 32'd0);
        check("rst_fetch_ready", 32'(fetchReadyOut), 32'd0);
        check("rst_error", 32'(errorOut), 32'd0);
        check("rst_addr", memoryAddressOut, 32'd0);
        resetIn = 1'b1;

        // Single fetch, memory answers in the third strobe cycle.
        fetchAddressIn = 32'h100;
        fetchLoadIn    = 1'b1;
        expect_resp(1'b1, 32'hDEADBEEF, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            next();
            check("fetch_load_strobe", 32'(memoryLoadOut), 32'd1);
            check("fetch_addr", memoryAddressOut, 32'h100);
        end
        memoryReadyIn = 1'b1;
        memoryValueIn = 32'hDEADBEEF;
        next();
        memoryReadyIn = 1'b0;
        memoryValueIn = '0;
        check("fetch_strobe_dropped", 32'(memoryLoadOut), 32'd0);
        next();
        fetchLoadIn = 1'b0;  // dropped one cycle after seeing ready
        check("fetch_idle_load", 32'(memoryLoadOut), 32'd0);
        check("fetch_idle_ready", 32'(fetchReadyOut), 32'd0);
        next();
        check("fetch_not_regranted", 32'(memoryLoadOut), 32'd0);

        // Store: completion value must be 0 whatever memory drives.
        accessAddressIn = 32'h200;
        accessValueIn   = 32'h12345678;
        accessStoreIn   = 1'b1;
        expect_resp(1'b0, 32'd0, 1'b0);
        next();
        check("store_strobe", 32'(memoryStoreOut), 32'd1);
        check("store_no_load", 32'(memoryLoadOut), 32'd0);
        check("store_data", memoryValueOut, 32'h12345678);
        check("store_addr", memoryAddressOut, 32'h200);
        next();
        memoryReadyIn = 1'b1;
        memoryValueIn = 32'hFFFFFFFF;
        next();
        memoryReadyIn = 1'b0;
        check("store_strobe_dropped", 32'(memoryStoreOut), 32'd0);
        next();
        accessStoreIn = 1'b0;
        next();

        // Spurious memory ready while idle.
        memoryReadyIn = 1'b1;
        memoryValueIn = 32'h11111111;
        next();
        memoryReadyIn = 1'b0;
        check("spurious_no_load", 32'(memoryLoadOut), 32'd0);
        check("spurious_no_store", 32'(memoryStoreOut), 32'd0);
        next();
        check("spurious_no_ready", 32'({fetchReadyOut, accessReadyOut}), 32'd0);
        check("spurious_fetch_value", fetchValueOut, exp_fetch_val);

        // Load and store together behave as a store.
        accessAddressIn = 32'h600;
        accessValueIn   = 32'h77;
        accessLoadIn    = 1'b1;
        accessStoreIn   = 1'b1;
        expect_resp(1'b0, 32'd0, 1'b0);
        next();
        check("dual_store", 32'(memoryStoreOut), 32'd1);
        check("dual_no_load", 32'(memoryLoadOut), 32'd0);
        check("dual_data", memoryValueOut, 32'h77);
        memoryReadyIn = 1'b1;
        memoryValueIn = 32'hABCD;
        next();
        memoryReadyIn = 1'b0;
        next();
        accessLoadIn  = 1'b0;
        accessStoreIn = 1'b0;
        next();

        // Watchdog abort after 4 strobe cycles.
        fetchAddressIn = 32'h500;
        fetchLoadIn    = 1'b1;
        expect_resp(1'b1, 32'd0, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            next();
            check("tmo_strobe", 32'(memoryLoadOut), 32'd1);
        end
        next();
        check("tmo_strobe_dropped", 32'(memoryLoadOut), 32'd0);
        check("tmo_error", 32'(errorOut), 32'd1);
        next();
        fetchLoadIn = 1'b0;
        next();

        // Next request after abort at minimum latency.
        fetchAddressIn = 32'h504;
        fetchLoadIn    = 1'b1;
        expect_resp(1'b1, 32'hCAFEF00D, 1'b0);
        next();
        check("post_tmo_addr", memoryAddressOut, 32'h504);
        memoryReadyIn = 1'b1;
        memoryValueIn = 32'hCAFEF00D;
        next();
        memoryReadyIn = 1'b0;
        check("min_latency_ready", 32'(fetchReadyOut), 32'd1);
        next();
        fetchLoadIn = 1'b0;
        next();

        // Ready in the abort cycle wins over the watchdog.
        fetchAddressIn = 32'h508;
        fetchLoadIn    = 1'b1;
        expect_resp(1'b1, 32'h55AA55AA, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            next();
            check("race_strobe", 32'(memoryLoadOut), 32'd1);
        end
        memoryReadyIn = 1'b1;
        memoryValueIn = 32'h55AA55AA;
        next();
        memoryReadyIn = 1'b0;
        check("race_no_error", 32'(errorOut), 32'd0);
        next();
        fetchLoadIn = 1'b0;
        next();

        // Contention from reset: access first, then alternate.
        resetIn = 1'b0;
        next();
        exp_fetch_val  = '0;
        exp_access_val = '0;
        resetIn        = 1'b1;
        fetchAddressIn  = 32'h300;
        fetchLoadIn     = 1'b1;
        accessAddressIn = 32'h400;
        accessLoadIn    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic        acc;
            logic [31:0] v;
            acc = (i % 2 == 0);
            v   = acc ? (32'hA0000000 + 32'(i)) : (32'hF0000000 + 32'(i));
            next();
            check("contend_addr", memoryAddressOut, acc ? 32'h400 : 32'h300);
            check("contend_load", 32'(memoryLoadOut), 32'd1);
            memoryReadyIn = 1'b1;
            memoryValueIn = v;
            expect_resp(!acc, v, 1'b0);
            next();
            memoryReadyIn = 1'b0;
            if (i == 3) begin
                fetchLoadIn  = 1'b0;
                accessLoadIn = 1'b0;
            end
            next();
        end
        next();

        // Asynchronous reset in the middle of a store.
        accessAddressIn = 32'h700;
        accessValueIn   = 32'h99;
        accessStoreIn   = 1'b1;
        next();
        check("mid_store_active", 32'(memoryStoreOut), 32'd1);
        #1 resetIn = 1'b0;
        #1;
        check("arst_store", 32'(memoryStoreOut), 32'd0);
        check("arst_load", 32'(memoryLoadOut), 32'd0);
        check("arst_addr", memoryAddressOut, 32'd0);
        check("arst_wdata", memoryValueOut, 32'd0);
        check("arst_fetch_value", fetchValueOut, 32'd0);
        check("arst_access_value", accessValueOut, 32'd0);
        check("arst_readies", 32'({fetchReadyOut, accessReadyOut, errorOut}), 32'd0);
        exp_fetch_val  = '0;
        exp_access_val = '0;
        accessStoreIn  = 1'b0;
        next();
        resetIn = 1'b1;
        fetchAddressIn  = 32'h800;
        fetchLoadIn     = 1'b1;
        accessAddressIn = 32'h900;
        accessLoadIn    = 1'b1;
        next();
        check("post_rst_grant_access", memoryAddressOut, 32'h900);
        memoryReadyIn = 1'b1;
        memoryValueIn = 32'h13579BDF;
        expect_resp(1'b0, 32'h13579BDF, 1'b0);
        next();
        memoryReadyIn = 1'b0;
        fetchLoadIn   = 1'b0;
        accessLoadIn  = 1'b0;
        next();
        next();

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares the single external memory port between the fetch stage (loads only) and the access stage (loads and stores).
- Each requester gets a simple request/ready handshake.
- Contention is resolved by alternating priority, so neither stage starves.
- A watchdog aborts transactions whose memory never answers.

Parameters:
- WIDTH, 32: address and data width in bits.
- TIMEOUT, 255: cycles a granted transaction may wait for memoryReadyIn before abort; 0 disables the watchdog.

Ports:
- clockIn  input  1  single clock, rising edge.
- resetIn  input  1  asynchronous, active-low reset.
- fetchAddressIn  input  WIDTH  fetch load address.
- fetchLoadIn  input  1  fetch request; level, held until fetchReadyOut seen.
- fetchValueOut  output  WIDTH  fetch load result, valid with fetchReadyOut.
- fetchReadyOut  output  1  one-cycle completion pulse to fetch.
- accessAddressIn  input  WIDTH  access address.
- accessValueIn  input  WIDTH  store data.
- accessLoadIn  input  1  access load request; level.
- accessStoreIn  input  1  access store request; level.
- accessValueOut  output  WIDTH  access load result, valid with accessReadyOut.
- accessReadyOut  output  1  one-cycle completion pulse to access.
- memoryAddressOut  output  WIDTH  address to memory.
- memoryValueOut  output  WIDTH  store data to memory.
- memoryLoadOut  output  1  memory load strobe, held for the whole transaction.
- memoryStoreOut  output  1  memory store strobe, held for the whole transaction.
- memoryValueIn  input  WIDTH  memory read data, valid with memoryReadyIn.
- memoryReadyIn  input  1  memory completion.
- errorOut  output  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (asynchronous, resetIn=0): state IDLE, last-grant bit = fetch, watchdog counter 0, every output 0. Takes effect immediately, including mid-transaction. The memory strobes drop with no completion pulse.
- States: IDLE, FETCH, ACCESS, RESPOND.
- IDLE:
  - Sample requests. Access is pending if accessLoadIn or accessStoreIn is set; fetch is pending if fetchLoadIn is set.
  - Only one pending: grant it.
  - Both pending: grant the requester not named by the last-grant bit, so that after an access grant, fetch wins, and vice versa.
  - Neither pending: stay in IDLE.
- Grant (edge at end of cycle N):
  - Register address, store data and operation.
  - Set the last-grant bit.
  - Next state FETCH or ACCESS.
  - Strobes and address are asserted from cycle N+1, driven from registers, so later requester changes are ignored.
- accessLoadIn and accessStoreIn both high: treated as a store; memoryLoadOut stays 0.
- Strobes are mutually exclusive and never both 1.
- FETCH/ACCESS:
  - Hold the strobes and increment the watchdog counter each cycle.
  - On memoryReadyIn=1 in cycle M:
    - Capture memoryValueIn into the granted requester's value output. For a store, the value output is 0.
    - Drop the strobes, clear the counter, go to RESPOND.
  - The matching ready pulse is high during cycle M+1.
  - The other requester's value output is unchanged.
- Minimum latency: request at cycle N, memoryReadyIn in N+1, ready pulse at N+2.
- Watchdog: if TIMEOUT>0 and the counter reaches TIMEOUT with no memoryReadyIn:
  - Drop the strobes and go to RESPOND.
  - Value output = 0; ready pulse and errorOut both high in the RESPOND cycle.
  - A memoryReadyIn arriving in that same cycle takes precedence over the abort (normal completion, no error).
- RESPOND: lasts exactly one cycle; requests are ignored; then IDLE. This guarantees a requester dropping its request one cycle after seeing ready is never re-granted.
- memoryReadyIn in IDLE or RESPOND: ignored, no effect.
- Value outputs hold their last value between completions. Ready and errorOut are 0 outside RESPOND.
- Counter width: ceil(log2(TIMEOUT+1)), minimum 1 bit; it never wraps.

Test Plan:
- Single fetch: fetchAddressIn=0x100, fetchLoadIn=1 at cycle 0, memory returns 0xDEADBEEF with ready at cycle 3 -> memoryLoadOut=1 and memoryAddressOut=0x100 in cycles 1-3; fetchReadyOut=1 and fetchValueOut=0xDEADBEEF in cycle 4; IDLE in cycle 5.
- Store: accessAddressIn=0x200, accessValueIn=0x12345678, accessStoreIn=1, memory ready one cycle after the strobe -> memoryStoreOut=1, memoryValueOut=0x12345678, memoryLoadOut=0; accessReadyOut pulse with accessValueOut=0.
- Contention: both request continuously from reset -> grants alternate fetch-first? No: the last-grant bit resets to fetch, so the first grant is access, then fetch, access, fetch; no requester is granted twice in a row while the other is pending.
- Timeout: TIMEOUT=4, fetch request, memoryReadyIn held 0 -> strobe for 4 cycles; then fetchReadyOut=1, errorOut=1, fetchValueOut=0 for one cycle; the next request proceeds normally.
- Reset mid-transaction: resetIn=0 while in ACCESS with memoryStoreOut=1 -> all outputs 0 in the same cycle with no clock edge needed; after release, the next grant uses the reset last-grant bit.
- Spurious ready: memoryReadyIn=1 pulsed in IDLE with no requests -> no ready pulse, no state change; a dual load+store access request issues a store only.
